// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums frames of COUNT unsigned 4-bit products
// into an ACC_W-bit accumulator and offers the result over valid/ready.
module product_accumulator #(
    parameter int COUNT = 4,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept_s;
    logic [ACC_W:0]   sum_s;

    assign in_ready = (state_q == ACCUM) && !clear;
    assign accept_s = in_valid && in_ready;
    // One extra bit catches the carry out of the accumulator width.
    assign sum_s    = {1'b0, acc_q} + {{(ACC_W - 3){1'b0}}, in_p};

    assign out_valid = (state_q == DONE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    // Next-state and datapath update for the frame FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (clear) begin
                    acc_d = {ACC_W{1'b0}};
                    cnt_d = {CNT_W{1'b0}};
                    ovf_d = 1'b0;
                end else if (accept_s) begin
                    acc_d = sum_s[ACC_W-1:0];
                    ovf_d = ovf_q | sum_s[ACC_W];
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                // A clear with or without out_ready lands in the same place.
                if (clear || out_ready) begin
                    state_d = ACCUM;
                    acc_d   = {ACC_W{1'b0}};
                    ovf_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = ACCUM;
                acc_d   = {ACC_W{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
